// File: rtl/stack_pkg.sv
// Shared opcode/state encodings and default sizing for the stack unit.
package stack_pkg;

   localparam int STACK_DATA_W = 8;
   localparam int STACK_DEPTH  = 8;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_PUSH = 3'b001,
      OP_POP  = 3'b010,
      OP_PEEK = 3'b011,
      OP_DUP  = 3'b100,
      OP_SWAP = 3'b101
   } cmd_op_e;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWAP2 = 1'b1
   } state_e;

endpackage

// File: rtl/stack_unit_if.sv
// Command/response bundle between a stack client (master) and the stack unit (slave).
interface stack_unit_if
   import stack_pkg::*;
#(
   parameter int DATA_W = STACK_DATA_W,
   parameter int DEPTH  = STACK_DEPTH
);

   logic                       cmd_valid;
   logic                       cmd_ready;
   logic [2:0]                 cmd_op;
   logic [DATA_W-1:0]          wr_data;
   logic [DATA_W-1:0]          rd_data;
   logic                       rd_valid;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       full;
   logic                       empty;
   logic                       err;
   logic                       err_clr;

   modport master (
      output cmd_valid, cmd_op, wr_data, err_clr,
      input  cmd_ready, rd_data, rd_valid, count, full, empty, err
   );

   modport slave (
      input  cmd_valid, cmd_op, wr_data, err_clr,
      output cmd_ready, rd_data, rd_valid, count, full, empty, err
   );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, asynchronous reads of top and top-1.
module stack_mem
   import stack_pkg::*;
#(
   parameter int DATA_W = STACK_DATA_W,
   parameter int DEPTH  = STACK_DEPTH,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     topAddr_i,
   input  logic [AW-1:0]     belowAddr_i,
   output logic [DATA_W-1:0] topData_o,
   output logic [DATA_W-1:0] belowData_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage carries no reset; occupancy tracking in the parent hides stale entries.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign topData_o   = mem_q[topAddr_i];
   assign belowData_o = mem_q[belowAddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with PUSH/POP/PEEK/DUP/SWAP commands and error reporting.
// Define STACK_UNIT_STICKY_ERR_EN for a sticky err cleared by err_clr; otherwise err is a one-cycle pulse.
module stack_unit
   import stack_pkg::*;
#(
   parameter int DATA_W = STACK_DATA_W,
   parameter int DEPTH  = STACK_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   stack_unit_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] rdData_q, rdData_d;
   logic [DATA_W-1:0] swapTmp_q, swapTmp_d;
   logic              rdValid_q, rdValid_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              errEvent;

   logic              accept;
   logic              isFull, isEmpty;
   logic [AW-1:0]     countIdx, topIdx, belowIdx;
   logic              memWe;
   logic [AW-1:0]     memWaddr;
   logic [DATA_W-1:0] memWdata;
   logic [DATA_W-1:0] topData, belowData;

   assign accept   = bus.cmd_valid & ready_q;
   assign isFull   = (count_q == CW'(DEPTH));
   assign isEmpty  = (count_q == '0);
   assign countIdx = count_q[AW-1:0];
   assign topIdx   = countIdx - AW'(1);
   assign belowIdx = countIdx - AW'(2);

   stack_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk         (clk),
      .we_i        (memWe & rst),
      .waddr_i     (memWaddr),
      .wdata_i     (memWdata),
      .topAddr_i   (topIdx),
      .belowAddr_i (belowIdx),
      .topData_o   (topData),
      .belowData_o (belowData)
   );

   // Command decode. SWAP writes the old top-1 over the top and parks the old top,
   // which SWAP2 then writes into top-1, so one write port suffices.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rdData_d  = rdData_q;
      rdValid_d = 1'b0;
      swapTmp_d = swapTmp_q;
      ready_d   = ready_q;
      errEvent  = 1'b0;
      memWe     = 1'b0;
      memWaddr  = countIdx;
      memWdata  = bus.wr_data;

      if (state_q == SWAP2) begin
         memWe    = 1'b1;
         memWaddr = belowIdx;
         memWdata = swapTmp_q;
         state_d  = IDLE;
         ready_d  = 1'b1;
      end else if (accept) begin
         case (bus.cmd_op)
            OP_NOP: begin
            end
            OP_PUSH: begin
               if (isFull) begin
                  errEvent = 1'b1;
               end else begin
                  memWe   = 1'b1;
                  count_d = count_q + CW'(1);
               end
            end
            OP_POP, OP_PEEK: begin
               if (isEmpty) begin
                  errEvent = 1'b1;
               end else begin
                  rdData_d  = topData;
                  rdValid_d = 1'b1;
                  if (bus.cmd_op == OP_POP) begin
                     count_d = count_q - CW'(1);
                  end
               end
            end
            OP_DUP: begin
               if (isEmpty || isFull) begin
                  errEvent = 1'b1;
               end else begin
                  memWe    = 1'b1;
                  memWdata = topData;
                  count_d  = count_q + CW'(1);
               end
            end
            OP_SWAP: begin
               if (count_q < CW'(2)) begin
                  errEvent = 1'b1;
               end else begin
                  memWe     = 1'b1;
                  memWaddr  = topIdx;
                  memWdata  = belowData;
                  swapTmp_d = topData;
                  state_d   = SWAP2;
                  ready_d   = 1'b0;
               end
            end
            default: begin
               errEvent = 1'b1;
            end
         endcase
      end

`ifdef STACK_UNIT_STICKY_ERR_EN
      err_d = errEvent | (err_q & ~bus.err_clr);
`else
      err_d = errEvent;
`endif
   end

`ifndef STACK_UNIT_STICKY_ERR_EN
   logic unusedErrClr;
   assign unusedErrClr = bus.err_clr;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
         swapTmp_q <= '0;
         ready_q   <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rdData_q  <= rdData_d;
         rdValid_q <= rdValid_d;
         swapTmp_q <= swapTmp_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.rd_data   = rdData_q;
   assign bus.rd_valid  = rdValid_q;
   assign bus.count     = count_q;
   assign bus.full      = isFull;
   assign bus.empty     = isEmpty;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios then random commands against a queue model.
module tb_stack_unit;
   import stack_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   stack_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] model[$];
   logic [DATA_W-1:0] expRdData = '0;
   logic              expRdValid = 1'b0;
   logic              expErr = 1'b0;
   logic              expReady = 1'b1;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkValue("count",     32'(bus.count),     32'(model.size()));
      checkValue("empty",     32'(bus.empty),     32'(model.size() == 0));
      checkValue("full",      32'(bus.full),      32'(model.size() == DEPTH));
      checkValue("cmd_ready", 32'(bus.cmd_ready), 32'(expReady));
      checkValue("rd_valid",  32'(bus.rd_valid),  32'(expRdValid));
      checkValue("rd_data",   32'(bus.rd_data),   32'(expRdData));
      checkValue("err",       32'(bus.err),       32'(expErr));
   endtask

   // Drive one command for one clock, then advance the model and compare.
   task automatic applyStimulus(input logic [2:0] op, input logic [DATA_W-1:0] data,
                                input logic valid, input logic clr);
      logic              errEvt;
      logic [DATA_W-1:0] tmp;
      int                n;
      @(negedge clk);
      bus.cmd_valid = valid;
      bus.cmd_op    = op;
      bus.wr_data   = data;
      bus.err_clr   = clr;
      @(posedge clk);
      #1;
      errEvt     = 1'b0;
      expRdValid = 1'b0;
      n          = model.size();
      if (!expReady) begin
         expReady = 1'b1;
      end else if (valid) begin
         case (op)
            3'b000: ;
            3'b001: if (n == DEPTH) errEvt = 1'b1; else model.push_back(data);
            3'b010: if (n == 0) errEvt = 1'b1;
                    else begin expRdData = model.pop_back(); expRdValid = 1'b1; end
            3'b011: if (n == 0) errEvt = 1'b1;
                    else begin expRdData = model[n-1]; expRdValid = 1'b1; end
            3'b100: if (n == 0 || n == DEPTH) errEvt = 1'b1; else model.push_back(model[n-1]);
            3'b101: if (n < 2) errEvt = 1'b1;
                    else begin
                       tmp = model[n-1]; model[n-1] = model[n-2]; model[n-2] = tmp;
                       expReady = 1'b0;
                    end
            default: errEvt = 1'b1;
         endcase
      end
`ifdef STACK_UNIT_STICKY_ERR_EN
      expErr = errEvt | (expErr & ~clr);
`else
      expErr = errEvt;
`endif
      checkOutput();
   endtask

   task automatic applyReset(input logic [2:0] op, input logic valid);
      @(negedge clk);
      rst           = 1'b0;
      bus.cmd_valid = valid;
      bus.cmd_op    = op;
      bus.wr_data   = 8'hEE;
      bus.err_clr   = 1'b0;
      @(posedge clk);
      #1;
      model.delete();
      expRdData  = '0;
      expRdValid = 1'b0;
      expErr     = 1'b0;
      expReady   = 1'b1;
      checkOutput();
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'b000;
      bus.wr_data   = '0;
      bus.err_clr   = 1'b0;

      // Reset with a PUSH presented in the same cycle: it must be ignored.
      applyReset(OP_PUSH, 1'b1);

      // Basic push/pop ordering and rd_data hold.
      applyStimulus(OP_PUSH, 8'h11, 1'b1, 1'b0);
      applyStimulus(OP_PUSH, 8'h22, 1'b1, 1'b0);
      applyStimulus(OP_PUSH, 8'h33, 1'b1, 1'b0);
      applyStimulus(OP_POP,  8'h00, 1'b1, 1'b0);
      applyStimulus(OP_NOP,  8'h00, 1'b1, 1'b0);
      applyStimulus(OP_POP,  8'h00, 1'b0, 1'b0);

      // Overflow: fill, push while full, then pop the 8th value.
      applyReset(OP_NOP, 1'b0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(OP_PUSH, 8'(8'h80 + i), 1'b1, 1'b0);
      applyStimulus(OP_PUSH, 8'hAA, 1'b1, 1'b0);
      applyStimulus(OP_DUP,  8'h00, 1'b1, 1'b0);
      applyStimulus(OP_POP,  8'h00, 1'b1, 1'b0);

      // Underflow on empty, then error behaviour over following idle cycles.
      applyReset(OP_NOP, 1'b0);
      applyStimulus(OP_POP,  8'h00, 1'b1, 1'b0);
      applyStimulus(OP_NOP,  8'h00, 1'b1, 1'b0);
      applyStimulus(OP_NOP,  8'h00, 1'b1, 1'b1);
      applyStimulus(OP_PEEK, 8'h00, 1'b1, 1'b0);
      applyStimulus(OP_DUP,  8'h00, 1'b1, 1'b1);
      applyStimulus(OP_NOP,  8'h00, 1'b0, 1'b1);

      // SWAP with a POP held during SWAP2 (must not be accepted).
      applyReset(OP_NOP, 1'b0);
      applyStimulus(OP_PUSH, 8'h01, 1'b1, 1'b0);
      applyStimulus(OP_SWAP, 8'h00, 1'b1, 1'b0);
      applyStimulus(OP_PUSH, 8'h02, 1'b1, 1'b0);
      applyStimulus(OP_SWAP, 8'h00, 1'b1, 1'b0);
      applyStimulus(OP_POP,  8'h00, 1'b1, 1'b0);
      applyStimulus(OP_POP,  8'h00, 1'b1, 1'b0);
      applyStimulus(OP_POP,  8'h00, 1'b1, 1'b0);

      // DUP, PEEK and illegal opcode.
      applyReset(OP_NOP, 1'b0);
      applyStimulus(OP_PUSH, 8'h5A, 1'b1, 1'b0);
      applyStimulus(OP_DUP,  8'h00, 1'b1, 1'b0);
      applyStimulus(OP_PEEK, 8'h00, 1'b1, 1'b0);
      applyStimulus(3'b111,  8'h00, 1'b1, 1'b1);
      applyStimulus(3'b110,  8'h00, 1'b1, 1'b0);

      // Reset landing in SWAP2 aborts the swap.
      applyReset(OP_NOP, 1'b0);
      applyStimulus(OP_PUSH, 8'hC1, 1'b1, 1'b0);
      applyStimulus(OP_PUSH, 8'hC2, 1'b1, 1'b0);
      applyStimulus(OP_SWAP, 8'h00, 1'b1, 1'b0);
      applyReset(OP_POP, 1'b1);
      applyStimulus(OP_POP,  8'h00, 1'b1, 1'b0);

      // Random traffic against the queue model.
      for (int i = 0; i < 1500; i++) begin
         int r;
         logic [2:0] op;
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1, 2: op = OP_PUSH;
            3, 4:    op = OP_POP;
            5:       op = OP_PEEK;
            6:       op = OP_DUP;
            7:       op = OP_SWAP;
            8:       op = OP_NOP;
            default: op = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
         endcase
         if ($urandom_range(0, 199) == 0) begin
            applyReset(op, 1'b1);
         end else begin
            applyStimulus(op, 8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, maximum number of stored entries; SHALL be at least 2.
REQ-003 Port clk, input, 1, single clock for all logic; rising edge active.
REQ-004 Port rst, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port cmd_valid, input, 1, command present.
REQ-006 Port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are high on the same edge.
REQ-007 Port cmd_op, input, 3, command code: 000 NOP, 001 PUSH, 010 POP, 011 PEEK, 100 DUP, 101 SWAP, 110/111 illegal.
REQ-008 Port wr_data, input, DATA_W, PUSH operand.
REQ-009 Port rd_data, output, DATA_W, registered POP/PEEK result.
REQ-010 Port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-011 Port count, output, $clog2(DEPTH+1), current occupancy.
REQ-012 Ports full and empty, output, 1 each: full is (count == DEPTH); empty is (count == 0).
REQ-013 Port err, output, 1, error indication (see REQ-027).
REQ-014 Port err_clr, input, 1, clears a sticky error.

Function
REQ-015 NOP SHALL leave all state unchanged.
REQ-016 PUSH SHALL write wr_data at index count and increment count.
- PUSH in the same cycle as reset is ignored.
REQ-017 POP SHALL load rd_data with the top entry and decrement count.
- rd_valid is high in the cycle after acceptance.
REQ-018 PEEK SHALL behave as POP, with count unchanged.
REQ-019 DUP SHALL copy the top entry to index count and increment count.
REQ-020 SWAP SHALL exchange the top two entries over two cycles using states IDLE and SWAP2.
- IDLE to SWAP2: on accepted, legal SWAP; the first entry is latched.
- SWAP2 to IDLE: unconditionally; the write completes.
- cmd_ready is low in SWAP2 and high in IDLE.
REQ-021 Overflow: PUSH or DUP while full SHALL be accepted but rejected.
- Stack and count are unchanged.
- err fires.
REQ-022 Underflow: POP, PEEK or DUP while empty, or SWAP with count < 2, SHALL be rejected.
- State is unchanged.
- rd_valid stays low.
- err fires.
REQ-023 An illegal opcode SHALL act as NOP and fire err.
REQ-024 Entries beyond count SHALL NOT be observable; no wrap-around of count in either direction.
REQ-025 A read result SHALL hold rd_data until the next read result; rd_valid SHALL NOT assert without an accepted POP/PEEK.
REQ-026 Back-to-back commands SHALL be accepted every cycle in IDLE, at one op per cycle, except SWAP.

Reset
REQ-027 While rst is low at an edge, the block SHALL apply these values:
- count = 0, empty = 1, full = 0.
- rd_valid = 0, rd_data = 0, err = 0.
- State = IDLE, cmd_ready = 1 after the edge.
REQ-028 Reset asserted in SWAP2 SHALL abort the swap; storage contents are don't-care after reset.

Configuration
REQ-029 Macro STACK_UNIT_STICKY_ERR_EN selects err behaviour.
- Defined: err is set by any error and stays high until an edge with err_clr high and no new error; a new error wins over err_clr.
- Undefined: err is a one-cycle pulse in the cycle after the offending command, and err_clr is ignored.

Structure
REQ-030 Package stack_pkg SHALL hold:
- the cmd_op encodings as an enum;
- the FSM state enum {IDLE, SWAP2};
- the default DATA_W and DEPTH constants.
REQ-031 Storage SHALL be a sub-module stack_mem: a DEPTH x DATA_W register file with one synchronous write port and two asynchronous read ports (top, top-1); it has no reset.

Verification
REQ-032 Reset, then PUSH 0x11, 0x22, 0x33 on consecutive cycles, then POP -> rd_data 0x33 with rd_valid one cycle after acceptance; count 2.
REQ-033 Fill to DEPTH=8, then PUSH 0xAA -> full = 1, count stays 8, err fires, and a following POP returns the 8th pushed value, not 0xAA.
REQ-034 POP on empty -> err fires, rd_valid 0, count 0; with STACK_UNIT_STICKY_ERR_EN, err holds until err_clr.
REQ-035 PUSH 0x01, 0x02, then SWAP -> cmd_ready low for one cycle; then POP yields 0x01 and POP yields 0x02.
REQ-036 PUSH 0x5A, then DUP -> count 2; PEEK returns 0x5A with count still 2; opcode 111 -> err, count unchanged.
REQ-037 Assert rst low during SWAP2 -> next cycle count 0, empty 1, cmd_ready 1, err 0.
